// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler: grants issue to ready queue heads so that results never collide on the CDB.
// Ports:
//   clock, reset            - clock; asynchronous active-high reset
//   issueque_rdy_*          - a ready instruction waits at the head of int A / int B / ld-st / mul queue
//   flush                   - ROB flush: suppresses grants and drops every reservation
//   issue_grant_*           - combinational grants; the queue pops its head on the edge where grant=1
//   cdb_valid, cdb_sel      - registered CDB source (00 int A, 01 int B, 10 ld/st, 11 mul)
// Optional feature: define CDB_SCHED_INT_RR_EN for round-robin between integer A and B
// (otherwise A has fixed priority over B).
module cdb_issue_scheduler #(
    parameter int LDST_LAT = 2,
    parameter int MUL_LAT  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       issueque_rdy_int_A,
    input  logic       issueque_rdy_int_B,
    input  logic       issueque_rdy_ld_st,
    input  logic       issueque_rdy_mul,
    input  logic       flush,
    output logic       issue_grant_int_A,
    output logic       issue_grant_int_B,
    output logic       issue_grant_ld_st,
    output logic       issue_grant_mul,
    output logic       cdb_valid,
    output logic [1:0] cdb_sel
);
    // res[j] describes the CDB in cycle now+j-1; the extra top slot is permanently free
    logic [MUL_LAT:1]          res_v_q, res_v_d;
    logic [MUL_LAT:1][1:0]     res_own_q, res_own_d;
    logic [MUL_LAT+1:1]        ext_v;
    logic [MUL_LAT+1:1][1:0]   ext_own;
    logic                      en, pick_a, pick_b, g_int;
    assign ext_v   = {1'b0, res_v_q};
    assign ext_own = {2'b00, res_own_q};
    assign en      = !reset && !flush;
`ifdef CDB_SCHED_INT_RR_EN
    // last_int_q = 1 means integer A received the most recent integer grant
    logic last_int_q, last_int_d;
    assign pick_a     = issueque_rdy_int_A && (!issueque_rdy_int_B || !last_int_q);
    assign last_int_d = g_int ? issue_grant_int_A : last_int_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_int_q <= 1'b0;
        else       last_int_q <= last_int_d;
    end
`else
    assign pick_a = issueque_rdy_int_A;
`endif
    assign pick_b = issueque_rdy_int_B && !pick_a;
    always_comb begin
        issue_grant_int_A = en && !ext_v[2] && pick_a;
        issue_grant_int_B = en && !ext_v[2] && pick_b;
        issue_grant_ld_st = en && !ext_v[LDST_LAT+1] && issueque_rdy_ld_st;
        issue_grant_mul   = en && issueque_rdy_mul;
        g_int             = issue_grant_int_A || issue_grant_int_B;
    end
    always_comb begin
        res_v_d   = '0;
        res_own_d = '0;
        for (int j = 1; j <= MUL_LAT; j++) begin
            res_v_d[j]   = !flush && (ext_v[j+1] || (j == 1 && g_int) ||
                           (j == LDST_LAT && issue_grant_ld_st) || (j == MUL_LAT && issue_grant_mul));
            res_own_d[j] = (j == 1 && g_int) ? {1'b0, issue_grant_int_B} :
                           (j == LDST_LAT && issue_grant_ld_st) ? 2'b10 :
                           (j == MUL_LAT && issue_grant_mul) ? 2'b11 : ext_own[j+1];
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_v_q   <= '0;
            res_own_q <= '0;
        end else begin
            res_v_q   <= res_v_d;
            res_own_q <= res_own_d;
        end
    end
    assign cdb_valid = res_v_q[1];
    assign cdb_sel   = res_own_q[1];
endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// tb_cdb_issue_scheduler: scoreboard bench for cdb_issue_scheduler using an absolute-cycle result calendar.
module tb_cdb_issue_scheduler;
    localparam int LDST = 2;
    localparam int MUL  = 4;
    logic clock = 1'b0, reset = 1'b1;
    logic ra = 1'b0, rb = 1'b0, rl = 1'b0, rm = 1'b0, fl = 1'b0;
    logic ga, gb, gl, gm, cdb_valid;
    logic [1:0] cdb_sel;
    int checks = 0, errors = 0, cyc = 0;
    logic m_last = 1'b0;
    typedef struct {int due; logic [1:0] sel;} ent_t;
    ent_t q[$];

    cdb_issue_scheduler #(.LDST_LAT(LDST), .MUL_LAT(MUL)) dut (
        .clock(clock), .reset(reset),
        .issueque_rdy_int_A(ra), .issueque_rdy_int_B(rb),
        .issueque_rdy_ld_st(rl), .issueque_rdy_mul(rm), .flush(fl),
        .issue_grant_int_A(ga), .issue_grant_int_B(gb),
        .issue_grant_ld_st(gl), .issue_grant_mul(gm),
        .cdb_valid(cdb_valid), .cdb_sel(cdb_sel)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit busy(input int c);
        foreach (q[i]) if (q[i].due == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic a, input logic b, input logic l, input logic m, input logic f);
        logic pa, ea, eb, el, em;
        int idx;
        ra = a; rb = b; rl = l; rm = m; fl = f;
        #3;
`ifdef CDB_SCHED_INT_RR_EN
        pa = a && (!b || !m_last);
`else
        pa = a;
`endif
        ea = !f && pa && !busy(cyc + 1);
        eb = !f && b && !pa && !busy(cyc + 1);
        el = !f && l && !busy(cyc + LDST);
        em = !f && m;
        chk("grant_a", {7'd0, ga}, {7'd0, ea});
        chk("grant_b", {7'd0, gb}, {7'd0, eb});
        chk("grant_ls", {7'd0, gl}, {7'd0, el});
        chk("grant_mul", {7'd0, gm}, {7'd0, em});
        idx = -1;
        foreach (q[i]) if (q[i].due == cyc) idx = i;
        chk("cdb_valid", {7'd0, cdb_valid}, {7'd0, idx >= 0});
        if (idx >= 0) begin
            chk("cdb_sel", {6'd0, cdb_sel}, {6'd0, q[idx].sel});
            q.delete(idx);
        end
        if (f) q.delete();
        if (ea) q.push_back('{cyc + 1, 2'b00});
        if (eb) q.push_back('{cyc + 1, 2'b01});
        if (el) q.push_back('{cyc + LDST, 2'b10});
        if (em) q.push_back('{cyc + MUL, 2'b11});
        if (ea || eb) m_last = ea;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        ra = 1; rb = 1; rl = 1; rm = 1;
        #12;
        chk("rst_grant_a", {7'd0, ga}, 8'd0);
        chk("rst_grant_b", {7'd0, gb}, 8'd0);
        chk("rst_grant_ls", {7'd0, gl}, 8'd0);
        chk("rst_grant_mul", {7'd0, gm}, 8'd0);
        chk("rst_cdb_valid", {7'd0, cdb_valid}, 8'd0);
        chk("rst_cdb_sel", {6'd0, cdb_sel}, 8'd0);
        ra = 0; rb = 0; rl = 0; rm = 0;
        reset = 0;
        @(posedge clock);
        #1;
        cyc = 0;
        step(1, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 0);
        idle(2);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 1, 1, 0);
        idle(5);
        step(0, 0, 0, 1, 0);
        idle(1);
        step(1, 0, 0, 0, 1);
        idle(4);
        step(0, 0, 1, 1, 0);
        idle(1);
        // ld/st result is on the CDB now; mul still in flight
        chk("pre_pulse_valid", {7'd0, cdb_valid}, 8'd1);
        reset = 1;
        #1;
        chk("pulse_valid", {7'd0, cdb_valid}, 8'd0);
        chk("pulse_grant_mul", {7'd0, gm}, 8'd0);
        reset = 0;
        q.delete();
        m_last = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        idle(6);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        idle(MUL + 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
